// File: rtl/zap_cp15_unit_pkg.sv
// Shared CP15 encodings: CPU modes, MCR/MRC match patterns, CRn/CRm codes and the
// physical register-file bank layout used for register translation.
package zap_cp15_unit_pkg;

    localparam logic [4:0] USR = 5'h10;
    localparam logic [4:0] FIQ = 5'h11;
    localparam logic [4:0] IRQ = 5'h12;
    localparam logic [4:0] SVC = 5'h13;
    localparam logic [4:0] ABT = 5'h17;
    localparam logic [4:0] UND = 5'h1B;
    localparam logic [4:0] SYS = 5'h1F;

    // Coprocessor register transfers: bits 27:24 = 1110 with bit 4 set; bit 20 selects direction.
    localparam logic [31:0] MCR_PAT = 32'b????_1110_???0_????_????_????_???1_????;
    localparam logic [31:0] MRC_PAT = 32'b????_1110_???1_????_????_????_???1_????;

    localparam logic [3:0] CP15_NUM  = 4'd15;
    localparam logic [3:0] PC_IDX    = 4'd15;

    localparam logic [3:0] CRN_ID    = 4'd0;
    localparam logic [3:0] CRN_CTRL  = 4'd1;
    localparam logic [3:0] CRN_TTBR  = 4'd2;
    localparam logic [3:0] CRN_DAC   = 4'd3;
    localparam logic [3:0] CRN_FSR   = 4'd5;
    localparam logic [3:0] CRN_FAR   = 4'd6;
    localparam logic [3:0] CRN_CACHE = 4'd7;
    localparam logic [3:0] CRN_TLB   = 4'd8;

    localparam logic [3:0] CRM_INV       = 4'd7;
    localparam logic [3:0] CRM_CLEAN     = 4'd10;
    localparam logic [3:0] CRM_CLEAN_INV = 4'd14;

    // Banked registers live above the 16 base registers.
    localparam int FIQ_BASE = 16;   // R8..R14 -> 16..22
    localparam int IRQ_BASE = 23;   // R13..R14
    localparam int SVC_BASE = 25;
    localparam int ABT_BASE = 27;
    localparam int UND_BASE = 29;

endpackage

// File: rtl/zap_cp15_unit_translate.sv
// Combinational architectural-to-physical register index map (banked per mode).
module zap_cp15_translate
    import zap_cp15_unit_pkg::*;
#(
    parameter  int PHY_REGS = 46,
    localparam int IDX      = $clog2(PHY_REGS)
) (
    input  logic [3:0]     i_rd,
    input  logic [4:0]     i_mode,
    output logic [IDX-1:0] o_index
);

    always_comb begin
        o_index = IDX'(i_rd);
        if (i_mode == FIQ && i_rd >= 4'd8 && i_rd != PC_IDX) begin
            o_index = IDX'(FIQ_BASE) + IDX'(i_rd - 4'd8);
        end else if (i_rd == 4'd13 || i_rd == 4'd14) begin
            case (i_mode)
                IRQ:     o_index = IDX'(IRQ_BASE) + IDX'(i_rd - 4'd13);
                SVC:     o_index = IDX'(SVC_BASE) + IDX'(i_rd - 4'd13);
                ABT:     o_index = IDX'(ABT_BASE) + IDX'(i_rd - 4'd13);
                UND:     o_index = IDX'(UND_BASE) + IDX'(i_rd - 4'd13);
                default: o_index = IDX'(i_rd);
            endcase
        end
    end

endmodule

// File: rtl/zap_cp15_unit.sv
// CP15 system-control coprocessor: MCR/MRC through the physical register file,
// cache/TLB maintenance sequencing, MMU fault capture, done handshake to decode.
module zap_cp15_unit
    import zap_cp15_unit_pkg::*;
#(
    parameter  int          PHY_REGS = 46,
    parameter  logic [31:0] CP15_ID  = 32'h4100_0000,
    localparam int          IDX      = $clog2(PHY_REGS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cp_dav,
    input  logic [31:0]     i_cp_word,
    input  logic [4:0]      i_cpsr_mode,
    output logic            o_cp_done,
    output logic            o_reg_en,
    output logic [IDX-1:0]  o_reg_rd_index,
    input  logic [31:0]     i_reg_rd_data,
    output logic [IDX-1:0]  o_reg_wr_index,
    output logic [31:0]     o_reg_wr_data,
    output logic            o_reg_wr_en,
    output logic [31:0]     o_ctrl,
    output logic [31:0]     o_ttbr,
    output logic [31:0]     o_dac,
    output logic [31:0]     o_fsr,
    output logic [31:0]     o_far,
    output logic            o_cache_inv,
    output logic            o_cache_clean,
    output logic            o_tlb_inv,
    input  logic            i_cache_inv_done,
    input  logic            i_cache_clean_done,
    input  logic            i_tlb_inv_done,
    input  logic            i_fault_valid,
    input  logic [7:0]      i_fsr,
    input  logic [31:0]     i_far
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REG, S_MAINT, S_DONE
    } state_t;

    state_t r_state;

    logic [3:0]     w_crn, w_rd, w_cpn, w_crm;
    logic [2:0]     w_opc1;
    logic           w_mcr, w_mrc, w_cp15_op;
    logic           w_inv, w_clean, w_tlb;
    logic           w_inv_left, w_clean_left, w_tlb_left;
    logic [IDX-1:0] w_phys;
    logic [31:0]    w_rd_val;

    assign w_crn  = i_cp_word[19:16];
    assign w_rd   = i_cp_word[15:12];
    assign w_cpn  = i_cp_word[11:8];
    assign w_crm  = i_cp_word[3:0];
    assign w_opc1 = i_cp_word[23:21];

    always_comb begin
        w_mcr = 1'b0;
        w_mrc = 1'b0;
        casez (i_cp_word)
            MCR_PAT: w_mcr = 1'b1;
            MRC_PAT: w_mrc = 1'b1;
            default: ;
        endcase
    end

    // Anything that is not an opcode1=0 transfer to cp15 is completed as a NOP.
    assign w_cp15_op = (w_mcr || w_mrc) && (w_cpn == CP15_NUM) && (w_opc1 == 3'd0);

    assign w_inv   = (w_crn == CRN_CACHE) && (w_crm == CRM_INV   || w_crm == CRM_CLEAN_INV);
    assign w_clean = (w_crn == CRN_CACHE) && (w_crm == CRM_CLEAN || w_crm == CRM_CLEAN_INV);
    assign w_tlb   = (w_crn == CRN_TLB);

    assign w_inv_left   = o_cache_inv   && !i_cache_inv_done;
    assign w_clean_left = o_cache_clean && !i_cache_clean_done;
    assign w_tlb_left   = o_tlb_inv     && !i_tlb_inv_done;

    always_comb begin
        case (w_crn)
            CRN_ID:   w_rd_val = CP15_ID;
            CRN_CTRL: w_rd_val = o_ctrl;
            CRN_TTBR: w_rd_val = o_ttbr;
            CRN_DAC:  w_rd_val = o_dac;
            CRN_FSR:  w_rd_val = o_fsr;
            CRN_FAR:  w_rd_val = o_far;
            default:  w_rd_val = 32'd0;
        endcase
    end

    zap_cp15_translate #(.PHY_REGS(PHY_REGS)) u_translate (
        .i_rd    (w_rd),
        .i_mode  (i_cpsr_mode),
        .o_index (w_phys)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            o_cp_done      <= 1'b0;
            o_reg_en       <= 1'b0;
            o_reg_rd_index <= '0;
            o_reg_wr_index <= '0;
            o_reg_wr_data  <= 32'd0;
            o_reg_wr_en    <= 1'b0;
            o_ctrl         <= 32'd0;
            o_ttbr         <= 32'd0;
            o_dac          <= 32'd0;
            o_fsr          <= 32'd0;
            o_far          <= 32'd0;
            o_cache_inv    <= 1'b0;
            o_cache_clean  <= 1'b0;
            o_tlb_inv      <= 1'b0;
        end else begin
            o_reg_en    <= 1'b0;
            o_reg_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: if (i_cp_dav) begin
                    if (!w_cp15_op) begin
                        r_state   <= S_DONE;
                        o_cp_done <= 1'b1;
                    end else if (w_mcr) begin
                        r_state        <= S_RD_REQ;
                        o_reg_en       <= 1'b1;
                        o_reg_rd_index <= w_phys;
                    end else begin
                        r_state        <= S_WR_REG;
                        o_reg_wr_en    <= (w_rd != PC_IDX);
                        o_reg_wr_index <= w_phys;
                        o_reg_wr_data  <= w_rd_val;
                    end
                end
                S_RD_REQ: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    case (w_crn)
                        CRN_CTRL: o_ctrl <= i_reg_rd_data;
                        CRN_TTBR: o_ttbr <= i_reg_rd_data;
                        CRN_DAC:  o_dac  <= i_reg_rd_data;
                        CRN_FSR:  o_fsr  <= i_reg_rd_data;
                        CRN_FAR:  o_far  <= i_reg_rd_data;
                        default: ;
                    endcase
                    if (w_inv || w_clean || w_tlb) begin
                        r_state       <= S_MAINT;
                        o_cache_inv   <= w_inv;
                        o_cache_clean <= w_clean;
                        o_tlb_inv     <= w_tlb;
                    end else begin
                        r_state   <= S_DONE;
                        o_cp_done <= 1'b1;
                    end
                end
                S_WR_REG: begin
                    r_state   <= S_DONE;
                    o_cp_done <= 1'b1;
                end
                S_MAINT: begin
                    o_cache_inv   <= w_inv_left;
                    o_cache_clean <= w_clean_left;
                    o_tlb_inv     <= w_tlb_left;
                    if (!(w_inv_left || w_clean_left || w_tlb_left)) begin
                        r_state   <= S_DONE;
                        o_cp_done <= 1'b1;
                    end
                end
                S_DONE: if (!i_cp_dav) begin
                    r_state   <= S_IDLE;
                    o_cp_done <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // Fault capture overrides any same-cycle MCR to c5/c6.
            if (i_fault_valid) begin
                o_fsr <= {24'd0, i_fsr};
                o_far <= i_far;
            end
        end
    end

endmodule

// File: tb/tb_zap_cp15_unit.sv
// Randomized scoreboard bench for zap_cp15_unit against a behavioural CP15 model.
module tb_zap_cp15_unit;
    import zap_cp15_unit_pkg::*;

    localparam int PHY_REGS = 46;
    localparam int IDX      = $clog2(PHY_REGS);

    logic            i_clk = 1'b0, i_reset = 1'b1, i_cp_dav = 1'b0;
    logic [31:0]     i_cp_word = 32'd0, i_reg_rd_data = 32'd0, i_far = 32'd0;
    logic [4:0]      i_cpsr_mode = USR;
    logic            i_cache_inv_done = 1'b0, i_cache_clean_done = 1'b0, i_tlb_inv_done = 1'b0;
    logic            i_fault_valid = 1'b0;
    logic [7:0]      i_fsr = 8'd0;
    logic            o_cp_done, o_reg_en, o_reg_wr_en, o_cache_inv, o_cache_clean, o_tlb_inv;
    logic [IDX-1:0]  o_reg_rd_index, o_reg_wr_index;
    logic [31:0]     o_reg_wr_data, o_ctrl, o_ttbr, o_dac, o_fsr, o_far;

    always #5 i_clk = ~i_clk;

    zap_cp15_unit #(.PHY_REGS(PHY_REGS), .CP15_ID(32'h4100_0000)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cp_dav(i_cp_dav), .i_cp_word(i_cp_word),
        .i_cpsr_mode(i_cpsr_mode), .o_cp_done(o_cp_done), .o_reg_en(o_reg_en),
        .o_reg_rd_index(o_reg_rd_index), .i_reg_rd_data(i_reg_rd_data),
        .o_reg_wr_index(o_reg_wr_index), .o_reg_wr_data(o_reg_wr_data), .o_reg_wr_en(o_reg_wr_en),
        .o_ctrl(o_ctrl), .o_ttbr(o_ttbr), .o_dac(o_dac), .o_fsr(o_fsr), .o_far(o_far),
        .o_cache_inv(o_cache_inv), .o_cache_clean(o_cache_clean), .o_tlb_inv(o_tlb_inv),
        .i_cache_inv_done(i_cache_inv_done), .i_cache_clean_done(i_cache_clean_done),
        .i_tlb_inv_done(i_tlb_inv_done), .i_fault_valid(i_fault_valid), .i_fsr(i_fsr), .i_far(i_far)
    );

    typedef struct { int cyc; int idx; } rd_exp_t;
    typedef struct { int cyc; int idx; logic [31:0] data; } wr_exp_t;
    typedef struct { int cyc; logic [31:0] ctrl, ttbr, dac, fsr, far; } done_exp_t;

    rd_exp_t   q_rd[$];
    wr_exp_t   q_wr[$];
    done_exp_t q_done[$];
    rd_exp_t   er;
    wr_exp_t   ew;
    done_exp_t ed;

    int cyc = 0;
    int vectors = 0, miscompares = 0;
    int inv_lo = 1, inv_hi = 0, cln_lo = 1, cln_hi = 0, tlb_lo = 1, tlb_hi = 0;
    logic [31:0] rf [PHY_REGS];
    logic [31:0] m_ctrl = 0, m_ttbr = 0, m_dac = 0, m_fsr = 0, m_far = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural register -> physical slot: base file, then a bank per privileged mode.
    function automatic int exp_idx(input int rd, input logic [4:0] mode);
        int first, base;
        first = 16; base = 0;
        case (mode)
            FIQ: begin first = 8;  base = 16; end
            IRQ: begin first = 13; base = 23; end
            SVC: begin first = 13; base = 25; end
            ABT: begin first = 13; base = 27; end
            UND: begin first = 13; base = 29; end
            default: ;
        endcase
        if (rd >= first && rd <= 14) return base + rd - first;
        return rd;
    endfunction

    function automatic logic [31:0] cp15_read(input int crn);
        case (crn)
            0: return 32'h4100_0000;
            1: return m_ctrl;
            2: return m_ttbr;
            3: return m_dac;
            5: return m_fsr;
            6: return m_far;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input bit l, input int opc1, input int crn, input int rd,
                                       input int cp, input int crm);
        logic [31:0] w;
        w = 32'hEE00_0010;
        w[23:21] = opc1[2:0];
        w[20]    = l;
        w[19:16] = crn[3:0];
        w[15:12] = rd[3:0];
        w[11:8]  = cp[3:0];
        w[7:5]   = 3'($urandom);
        w[3:0]   = crm[3:0];
        return w;
    endfunction

    // Read-data responder: data for an index strobed in one cycle is returned in the next.
    logic           rd_pend = 1'b0;
    logic [IDX-1:0] rd_pidx = '0;
    always @(negedge i_clk) begin
        i_reg_rd_data = rd_pend ? rf[rd_pidx] : $urandom;
        rd_pend = o_reg_en;
        rd_pidx = o_reg_rd_index;
    end

    // Monitor: compares every DUT-presented event against the queued expectations.
    logic prev_done = 1'b0;
    always @(posedge i_clk) begin
        #1;
        chk("cache_inv",   32'(o_cache_inv),   32'(cyc >= inv_lo && cyc <= inv_hi));
        chk("cache_clean", 32'(o_cache_clean), 32'(cyc >= cln_lo && cyc <= cln_hi));
        chk("tlb_inv",     32'(o_tlb_inv),     32'(cyc >= tlb_lo && cyc <= tlb_hi));
        if (o_reg_en === 1'b1) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
                er = q_rd.pop_front();
                chk("rd_cycle", cyc, er.cyc);
                chk("rd_index", 32'(o_reg_rd_index), er.idx);
            end
        end
        if (o_reg_wr_en === 1'b1) begin
            if (q_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                ew = q_wr.pop_front();
                chk("wr_cycle", cyc, ew.cyc);
                chk("wr_index", 32'(o_reg_wr_index), ew.idx);
                chk("wr_data", o_reg_wr_data, ew.data);
            end
        end
        if (o_cp_done === 1'b1 && !prev_done) begin
            if (q_done.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
            else begin
                ed = q_done.pop_front();
                chk("done_cycle", cyc, ed.cyc);
                chk("ctrl", o_ctrl, ed.ctrl);
                chk("ttbr", o_ttbr, ed.ttbr);
                chk("dac",  o_dac,  ed.dac);
                chk("fsr",  o_fsr,  ed.fsr);
                chk("far",  o_far,  ed.far);
            end
        end
        prev_done = (o_cp_done === 1'b1);
    end

    // Issue one request; cycle 0 is the cycle in which dav is first sampled.
    // fki/fkc force the inv/clean done-pulse cycles (-1 = random); rst_at>0 resets in that cycle.
    task automatic run_req(input logic [31:0] w, input logic [4:0] mode, input bit fault_req,
                           input int rst_at, input int fki, input int fkc);
        bit is_cp, mrc, fault, inv, cln, tlb, s_i, s_c, s_t, done_seen;
        int crn, rd, crm, idx, lat, ki, kc, kt, c0;
        logic [31:0] v, fsr_v, far_v;
        is_cp = (w[27:24] == 4'b1110) && w[4] && (w[11:8] == 4'd15) && (w[23:21] == 3'd0);
        mrc = w[20];
        crn = int'(w[19:16]); rd = int'(w[15:12]); crm = int'(w[3:0]);
        idx = exp_idx(rd, mode);
        fault = fault_req && is_cp && !mrc;
        fsr_v = {24'd0, 8'($urandom)}; far_v = $urandom;
        ki = -1; kc = -1; kt = -1; inv = 0; cln = 0; tlb = 0;
        s_i = ($urandom_range(0, 3) == 0); s_c = ($urandom_range(0, 3) == 0); s_t = ($urandom_range(0, 3) == 0);
        @(negedge i_clk);
        c0 = cyc;
        i_cp_word = w; i_cpsr_mode = mode; i_cp_dav = 1'b1;
        if (!is_cp) lat = 1;
        else if (mrc) begin
            lat = 2;
            if (rd != 15) q_wr.push_back('{c0 + 1, idx, cp15_read(crn)});
        end else begin
            v = rf[idx];
            q_rd.push_back('{c0 + 1, idx});
            case (crn)
                1: m_ctrl = v; 2: m_ttbr = v; 3: m_dac = v; 5: m_fsr = v; 6: m_far = v;
                default: ;
            endcase
            if (fault) begin m_fsr = fsr_v; m_far = far_v; end
            inv = (crn == 7) && (crm == 7 || crm == 14);
            cln = (crn == 7) && (crm == 10 || crm == 14);
            tlb = (crn == 8);
            lat = 3;
            if (inv) begin ki = (fki >= 0) ? fki : 3 + $urandom_range(0, 6); inv_lo = c0 + 3; inv_hi = c0 + ki; end
            if (cln) begin kc = (fkc >= 0) ? fkc : 3 + $urandom_range(0, 6); cln_lo = c0 + 3; cln_hi = c0 + kc; end
            if (tlb) begin kt = 3 + $urandom_range(0, 6); tlb_lo = c0 + 3; tlb_hi = c0 + kt; end
            if (ki + 1 > lat) lat = ki + 1;
            if (kc + 1 > lat) lat = kc + 1;
            if (kt + 1 > lat) lat = kt + 1;
        end
        if (rst_at > 0) begin
            ki = 1000; kc = 1000; kt = 1000;
            if (inv) inv_hi = c0 + rst_at;
            if (cln) cln_hi = c0 + rst_at;
            if (tlb) tlb_hi = c0 + rst_at;
            m_ctrl = 0; m_ttbr = 0; m_dac = 0; m_fsr = 0; m_far = 0;
        end else begin
            q_done.push_back('{c0 + lat, m_ctrl, m_ttbr, m_dac, m_fsr, m_far});
        end
        done_seen = 0;
        for (int k = 0; k < 80 && !done_seen; k++) begin
            i_cache_inv_done   = (k == ki) || (k == 1 && s_i);
            i_cache_clean_done = (k == kc) || (k == 1 && s_c);
            i_tlb_inv_done     = (k == kt) || (k == 1 && s_t);
            i_fault_valid = fault && (k == 2);
            i_fsr = fsr_v[7:0]; i_far = far_v;
            i_reset = (rst_at > 0) && (k == rst_at);
            @(negedge i_clk);
            if (rst_at > 0) done_seen = (k == rst_at);
            else done_seen = (o_cp_done === 1'b1);
        end
        i_cache_inv_done = 0; i_cache_clean_done = 0; i_tlb_inv_done = 0;
        i_fault_valid = 0; i_reset = 0;
        if (rst_at > 0) begin
            i_cp_dav = 1'b0;
            chk("rst_done", 32'(o_cp_done), 0); chk("rst_reg_en", 32'(o_reg_en), 0);
            chk("rst_wr_en", 32'(o_reg_wr_en), 0); chk("rst_ctrl", o_ctrl, 0);
            chk("rst_ttbr", o_ttbr, 0); chk("rst_fsr", o_fsr, 0); chk("rst_far", o_far, 0);
            chk("rst_maint", {29'd0, o_cache_inv, o_cache_clean, o_tlb_inv}, 0);
            @(negedge i_clk);
            return;
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        else repeat ($urandom_range(0, 2)) begin
            @(negedge i_clk);
            chk("done_hold", 32'(o_cp_done), 1);
        end
        i_cp_dav = 1'b0; i_cp_word = $urandom;
        @(negedge i_clk);
        chk("done_drop", 32'(o_cp_done), 0);
        repeat ($urandom_range(0, 2)) @(negedge i_clk);
    endtask

    function automatic logic [31:0] rand_word();
        int crns [12] = '{0, 1, 2, 3, 5, 6, 7, 8, 4, 9, 7, 8};
        int crms [4]  = '{7, 10, 14, 3};
        int sel, crn, crm;
        logic [31:0] w;
        sel = $urandom_range(0, 11);
        crn = crns[$urandom_range(0, 11)];
        crm = (crn == 7) ? crms[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
        w = mk(1'($urandom), 0, crn, $urandom_range(0, 15), 15, crm);
        case (sel)
            0: w[23:21] = 3'($urandom_range(1, 7));
            1: w[11:8]  = 4'd14;
            2: w[4]     = 1'b0;
            3: begin w = $urandom; w[27:25] = 3'b110; end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [4:0] modes [7] = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};
        logic [31:0] w;
        for (int i = 0; i < PHY_REGS; i++) rf[i] = $urandom;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        chk("reset_done", 32'(o_cp_done), 0); chk("reset_reg_en", 32'(o_reg_en), 0);
        chk("reset_wr_en", 32'(o_reg_wr_en), 0); chk("reset_ctrl", o_ctrl, 0);
        chk("reset_ttbr", o_ttbr, 0); chk("reset_dac", o_dac, 0);
        chk("reset_fsr", o_fsr, 0); chk("reset_far", o_far, 0);

        rf[1] = 32'hDEAD_0000;
        run_req(mk(0, 0, 2, 1, 15, 0), SVC, 0, 0, -1, -1);        // MCR c2 <- R1
        run_req(mk(1, 0, 0, 2, 15, 0), USR, 0, 0, -1, -1);        // MRC R2 <- c0
        run_req(mk(1, 0, 2, 15, 15, 0), SVC, 0, 0, -1, -1);       // MRC Rd=15: no write
        run_req(mk(0, 0, 7, 0, 15, 14), USR, 0, 0, 5, 9);         // clean+inv, done at 10
        w = mk(0, 0, 1, 4, 15, 0); w[4] = 1'b0;
        run_req(w, USR, 0, 0, -1, -1);                            // CDP
        run_req(mk(0, 0, 1, 4, 14, 0), USR, 0, 0, -1, -1);        // cp14
        rf[exp_idx(3, USR)] = 32'h0000_1234;
        run_req(mk(0, 0, 6, 3, 15, 0), USR, 1, 0, -1, -1);        // fault beats MCR c6
        run_req(mk(0, 0, 7, 0, 15, 14), USR, 0, 4, -1, -1);       // reset in MAINT
        run_req(mk(0, 0, 1, 13, 15, 0), FIQ, 0, 0, -1, -1);
        run_req(mk(1, 0, 1, 14, 15, 0), IRQ, 0, 0, -1, -1);

        for (int n = 0; n < 200; n++)
            run_req(rand_word(), modes[$urandom_range(0, 6)], ($urandom_range(0, 3) == 0), 0, -1, -1);

        repeat (3) @(negedge i_clk);
        chk("q_rd_left", q_rd.size(), 0);
        chk("q_wr_left", q_wr.size(), 0);
        chk("q_done_left", q_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
